// File: rtl/acoustic_cam_pkg.sv
// Shared defaults and state encodings for the acoustic camera frame-buffer path.
package acoustic_cam_pkg;

    localparam int DW_DEF        = 24;
    localparam int AW_DEF        = 10;
    localparam int FRAME_LEN_DEF = 512;
    localparam int RD_LAT_DEF    = 1;

    typedef enum logic {
        W_SYNC,
        W_FILL
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_READ,
        R_DRAIN
    } rd_state_e;

endpackage

// File: rtl/fbuf_rd_seq.sv
// Reader sequencer: burst-reads one bank per request and delays issue strobe/index/last
// by the RAM read latency so they line up with RAM dout.
module fbuf_rd_seq
    import acoustic_cam_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int RD_LAT    = RD_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_req_i,
    input  logic          frame_avail_i,
    output logic          rd_bank_o,
    output logic          rel_o,
    output logic          ceb_o,
    output logic [AW-1:0] adb_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          m_valid_o,
    output logic [AW-2:0] m_idx_o,
    output logic          m_last_o
);

    localparam int IW  = AW - 1;
    localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    rd_state_e       state_q;
    logic [IW-1:0]   ridx_q;
    logic [DCW-1:0]  dcnt_q;
    logic            ceb_q;
    logic            busy_q;
    logic            done_q;
    logic            rd_bank_q;
    logic            iss_last;

    logic [RD_LAT-1:0] dvld_q;
    logic [RD_LAT-1:0] dlast_q;
    logic [IW-1:0]     didx_q [RD_LAT];

    assign iss_last = ceb_q && (ridx_q == LAST_IDX);
    // Bank is released once the last read has had RD_LAT cycles to come back.
    assign rel_o    = (state_q == R_DRAIN) && (dcnt_q == DCW'(RD_LAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= R_IDLE;
            ridx_q    <= '0;
            dcnt_q    <= '0;
            ceb_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                R_IDLE: begin
                    if (rd_req_i && frame_avail_i) begin
                        state_q <= R_READ;
                        ceb_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        ridx_q  <= '0;
                    end
                end
                R_READ: begin
                    if (ridx_q == LAST_IDX) begin
                        state_q <= R_DRAIN;
                        ceb_q   <= 1'b0;
                        dcnt_q  <= '0;
                    end else begin
                        ridx_q <= ridx_q + 1'b1;
                    end
                end
                R_DRAIN: begin
                    if (rel_o) begin
                        state_q   <= R_IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rd_bank_q <= ~rd_bank_q;
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvld_q  <= '0;
            dlast_q <= '0;
            for (int i = 0; i < RD_LAT; i++) didx_q[i] <= '0;
        end else begin
            dvld_q[0]  <= ceb_q;
            dlast_q[0] <= iss_last;
            didx_q[0]  <= ridx_q;
            for (int i = 1; i < RD_LAT; i++) begin
                dvld_q[i]  <= dvld_q[i-1];
                dlast_q[i] <= dlast_q[i-1];
                didx_q[i]  <= didx_q[i-1];
            end
        end
    end

    assign rd_bank_o = rd_bank_q;
    assign ceb_o     = ceb_q;
    assign adb_o     = {rd_bank_q, ridx_q};
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign m_valid_o = dvld_q[RD_LAT-1];
    assign m_last_o  = dlast_q[RD_LAT-1] & dvld_q[RD_LAT-1];
    assign m_idx_o   = didx_q[RD_LAT-1];

endmodule

// File: rtl/mic_pingpong_buf_ctrl.sv
// Ping-pong frame-buffer controller: the sample writer fills one RAM bank while the
// reader sequencer bursts the other out to the beamformer.
module mic_pingpong_buf_ctrl
    import acoustic_cam_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int AW        = AW_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int RD_LAT    = RD_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    input  logic          s_sof,
    input  logic [DW-1:0] s_data,
    input  logic          rd_req,
    output logic          frame_avail,
    output logic          rd_busy,
    output logic          rd_done,
    output logic          m_valid,
    output logic          m_last,
    output logic [AW-2:0] m_idx,
    output logic [DW-1:0] m_data,
    output logic          ovf,
    input  logic          ovf_clr,
    output logic          ram_cea,
    output logic [AW-1:0] ram_ada,
    output logic [DW-1:0] ram_din,
    output logic          ram_ceb,
    output logic          ram_oce,
    output logic [AW-1:0] ram_adb,
    input  logic [DW-1:0] ram_dout
);

    localparam int IW = AW - 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    wr_state_e      wst_q;
    logic [IW-1:0]  widx_q;
    logic           wr_bank_q;
    logic [1:0]     full_q, full_d;
    logic           ovf_q;
    logic           cea_q;
    logic [AW-1:0]  ada_q;
    logic [DW-1:0]  din_q;

    logic           rd_bank;
    logic           rel;
    logic           drop;
    logic           wr_en;
    logic [IW-1:0]  wr_idx;
    logic           wr_last;

    // A sample into a still-full bank is lost; sof always restarts at index 0.
    assign drop    = s_valid && full_q[wr_bank_q];
    assign wr_en   = s_valid && !full_q[wr_bank_q] && (s_sof || (wst_q == W_FILL));
    assign wr_idx  = s_sof ? '0 : widx_q;
    assign wr_last = wr_en && (wr_idx == LAST_IDX);

    always_comb begin
        full_d = full_q;
        if (wr_last) full_d[wr_bank_q] = 1'b1;
        if (rel)     full_d[rd_bank]   = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wst_q     <= W_SYNC;
            widx_q    <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            ovf_q     <= 1'b0;
            cea_q     <= 1'b0;
            ada_q     <= '0;
            din_q     <= '0;
        end else begin
            full_q <= full_d;
            cea_q  <= wr_en;
            if (wr_en) begin
                ada_q <= {wr_bank_q, wr_idx};
                din_q <= s_data;
                if (wr_last) begin
                    wst_q     <= W_SYNC;
                    widx_q    <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    wst_q  <= W_FILL;
                    widx_q <= wr_idx + 1'b1;
                end
            end else if (drop) begin
                wst_q <= W_SYNC;
            end
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    fbuf_rd_seq #(
        .AW        (AW),
        .FRAME_LEN (FRAME_LEN),
        .RD_LAT    (RD_LAT)
    ) u_rd_seq (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_req_i      (rd_req),
        .frame_avail_i (frame_avail),
        .rd_bank_o     (rd_bank),
        .rel_o         (rel),
        .ceb_o         (ram_ceb),
        .adb_o         (ram_adb),
        .busy_o        (rd_busy),
        .done_o        (rd_done),
        .m_valid_o     (m_valid),
        .m_idx_o       (m_idx),
        .m_last_o      (m_last)
    );

    assign frame_avail = full_q[rd_bank];
    assign ram_oce     = ram_ceb;
    assign ram_cea     = cea_q;
    assign ram_ada     = ada_q;
    assign ram_din     = din_q;
    assign m_data      = ram_dout;
    assign ovf         = ovf_q;

endmodule
